// File: rtl/fetch_ctrl_pkg.sv
// Shared types and select encodings for the fetch-stage next-PC controller.
package fetch_ctrl_pkg;

    // Controller state: running normally, or holding a redirect captured under stall
    typedef enum logic [0:0] {
        RUN     = 1'b0,
        PENDING = 1'b1
    } state_t;

    // Encodings of the PC mux select driven to the fetch stage
    localparam logic [1:0] PC_SEL_PC4     = 2'b00;
    localparam logic [1:0] PC_SEL_JUMP    = 2'b01;
    localparam logic [1:0] PC_SEL_BRANCH  = 2'b10;
    localparam logic [1:0] PC_SEL_PENDING = 2'b11;

endpackage

// File: rtl/fetch_redirect_controller_sat_counter.sv
// Saturating up-counter: counts inc pulses and sticks at all-ones, never wraps.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_r;

    // Count register: increments on inc until it reaches all-ones
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= '0;
        end else if (inc && (count_r != {WIDTH{1'b1}})) begin
            count_r <= count_r + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/fetch_redirect_controller.sv
// Next-PC sequencing for the fetch stage: picks PC+4, jump, branch or a redirect
// captured while stalled, drives the IF/ID squash, and counts redirects/stalls.
// Optional macro BRANCH_DELAY_SLOT_EN: delay-slot semantics, squash tied to 0.
module fetch_redirect_controller
    import fetch_ctrl_pkg::*;
#(
    parameter int PC_WIDTH    = 32,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   hazard,
    input  logic                   branchTakenInput,
    input  logic [PC_WIDTH-1:0]    pcBranchInput,
    input  logic                   jumpInput,
    input  logic [PC_WIDTH-1:0]    pcJumpInput,
    output logic                   pcWriteOutput,
    output logic [1:0]             pcSelectOutput,
    output logic [PC_WIDTH-1:0]    pcTargetOutput,
    output logic                   flushOutput,
    output logic                   pendingOutput,
    output logic [COUNT_WIDTH-1:0] redirectCountOutput,
    output logic [COUNT_WIDTH-1:0] stallCountOutput
);

    state_t                state_r;
    state_t                next_state_s;
    logic [PC_WIDTH-1:0]   pending_pc_r;
    logic                  pc_write_s;
    logic [1:0]            sel_s;
    logic [PC_WIDTH-1:0]   target_s;
    logic                  flush_s;
    logic                  capture_s;
    logic [PC_WIDTH-1:0]   capture_pc_s;
    logic                  redirect_inc_s;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= RUN;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Redirect target remembered while the pipeline is stalled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_pc_r <= '0;
        end else if (capture_s) begin
            pending_pc_r <= capture_pc_s;
        end else begin
            pending_pc_r <= pending_pc_r;
        end
    end

    // Next-state and next-PC selection; branch wins over jump
    always_comb begin
        next_state_s   = state_r;
        pc_write_s     = 1'b0;
        sel_s          = PC_SEL_PC4;
        target_s       = '0;
        flush_s        = 1'b0;
        capture_s      = 1'b0;
        capture_pc_s   = '0;
        redirect_inc_s = 1'b0;
        case (state_r)
            RUN: begin
                if (!hazard) begin
                    pc_write_s = 1'b1;
                    if (branchTakenInput) begin
                        sel_s          = PC_SEL_BRANCH;
                        target_s       = pcBranchInput;
                        flush_s        = 1'b1;
                        redirect_inc_s = 1'b1;
                    end else if (jumpInput) begin
                        sel_s          = PC_SEL_JUMP;
                        target_s       = pcJumpInput;
                        flush_s        = 1'b1;
                        redirect_inc_s = 1'b1;
                    end else begin
                        sel_s = PC_SEL_PC4;
                    end
                end else if (branchTakenInput || jumpInput) begin
                    // Stalled: park the chosen target until the stall releases
                    capture_s    = 1'b1;
                    capture_pc_s = branchTakenInput ? pcBranchInput : pcJumpInput;
                    next_state_s = PENDING;
                end else begin
                    pc_write_s = 1'b0;
                end
            end
            PENDING: begin
                // Live requests are the stalled decode instruction repeating; ignore them
                if (!hazard) begin
                    pc_write_s     = 1'b1;
                    sel_s          = PC_SEL_PENDING;
                    target_s       = pending_pc_r;
                    flush_s        = 1'b1;
                    redirect_inc_s = 1'b1;
                    next_state_s   = RUN;
                end else begin
                    pc_write_s = 1'b0;
                end
            end
            default: begin
                next_state_s = RUN;
            end
        endcase
    end

    // Outputs are forced low for as long as reset is held
    assign pcWriteOutput  = pc_write_s & ~reset;
    assign pcSelectOutput = reset ? PC_SEL_PC4 : sel_s;
    assign pcTargetOutput = reset ? {PC_WIDTH{1'b0}} : target_s;
    assign pendingOutput  = (state_r == PENDING) & ~reset;
`ifdef BRANCH_DELAY_SLOT_EN
    // The instruction behind a redirect is the delay slot and must execute
    assign flushOutput    = 1'b0;
`else
    assign flushOutput    = flush_s & ~reset;
`endif

    sat_counter #(.WIDTH(COUNT_WIDTH)) u_redirect_count (
        .clk   (clk),
        .reset (reset),
        .inc   (redirect_inc_s),
        .count (redirectCountOutput)
    );

    sat_counter #(.WIDTH(COUNT_WIDTH)) u_stall_count (
        .clk   (clk),
        .reset (reset),
        .inc   (hazard),
        .count (stallCountOutput)
    );

endmodule
